// File: rtl/store_align_unit_pkg.sv
// -----------------------------------------------------------------------------
// store_align_unit_pkg
//   Shared store-width encodings for the store alignment path, plus a helper
//   that turns a width code into a right-justified byte mask.
//   No ports (package).
// -----------------------------------------------------------------------------
package store_align_unit_pkg;

    // Store width encodings, shared with the load-extension path.
    localparam logic [1:0] ST_SB  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SW  = 2'b10;
    localparam logic [1:0] ST_RSV = 2'b11;

    // Right-justified byte mask for a width code; reserved code gives no bytes.
    function automatic logic [3:0] width_mask(input logic [1:0] width);
        case (width)
            ST_SB:   width_mask = 4'b0001;
            ST_SH:   width_mask = 4'b0011;
            ST_SW:   width_mask = 4'b1111;
            default: width_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// -----------------------------------------------------------------------------
// store_lane_shifter
//   Purely combinational: positions right-justified store data onto a
//   two-word (64-bit) byte-lane window and builds the matching byte mask.
//   Lanes [3:0] belong to the addressed word, lanes [7:4] to the next word.
// Ports:
//   o      in   2   byte offset within the word (addr[1:0])
//   width  in   2   store width code (SB/SH/SW/reserved)
//   data   in  32   right-justified store data
//   sh64   out 64   data masked to the store width, shifted left by 8*o
//   mask8  out  8   byte mask, shifted left by o
// -----------------------------------------------------------------------------
module store_lane_shifter
    import store_align_unit_pkg::*;
(
    input  logic [1:0]  o,
    input  logic [1:0]  width,
    input  logic [31:0] data,
    output logic [63:0] sh64,
    output logic [7:0]  mask8
);

    logic [3:0]  m4;
    logic [31:0] data_m;

    // NOTE: every output of a combinational block is assigned on every path,
    // so no latch can be inferred.
    always_comb begin
        m4     = width_mask(width);
        data_m = data & {{8{m4[3]}}, {8{m4[2]}}, {8{m4[1]}}, {8{m4[0]}}};
        sh64   = {32'b0, data_m} << {o, 3'b000};
        mask8  = {4'b0000, m4} << o;
    end

endmodule

// File: rtl/store_align_unit.sv
// -----------------------------------------------------------------------------
// store_align_unit
//   Converts a pipeline store request (byte address, right-justified data,
//   width) into word-aligned memory write beats with byte enables. Stores
//   that cross a word boundary take two beats when STORE_MISALIGN_SPLIT_EN is
//   defined; otherwise they are rejected with a store_err pulse and no beat.
// Parameters:
//   ADDR_W     byte-address width
//   ZERO_IDLE  nonzero: mem_addr/mem_wdata/mem_be read 0 while mem_valid=0
// Ports:
//   CPU_CLK, CPU_RST_N            clock, async active-low reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_addr, req_data, req_type  store byte address, data, width code
//   mem_valid/mem_ready           write beat handshake
//   mem_addr, mem_wdata, mem_be   word address, lane data, byte enables
//   store_done                    pulse: request fully written
//   store_err                     pulse: request rejected, no beat issued
// Build option: STORE_MISALIGN_SPLIT_EN
// -----------------------------------------------------------------------------
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int ZERO_IDLE = 1
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_type,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              store_done,
    output logic              store_err
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t            state, state_nxt;
    logic [63:0]       sh64;
    logic [7:0]        mask8;
    logic              crosses, reject, accept;
    logic              done_nxt, err_nxt;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [3:0]        be_r;

    // Lane placement is computed from the live request and captured at accept.
    store_lane_shifter u_shifter (
        .o     (req_addr[1:0]),
        .width (req_type),
        .data  (req_data),
        .sh64  (sh64),
        .mask8 (mask8)
    );

    assign crosses   = |mask8[7:4];
    assign req_ready = (state == IDLE);
    assign mem_valid = (state != IDLE);

`ifdef STORE_MISALIGN_SPLIT_EN
    logic        cross_r;
    logic [31:0] hi_wdata_r;
    logic [3:0]  hi_be_r;

    assign reject = (req_type == ST_RSV);
`else
    // Upper lanes only matter when splitting; here they only feed `crosses`.
    logic unused_hi;
    assign unused_hi = ^sh64[63:32];
    assign reject    = (req_type == ST_RSV) || crosses;
`endif

    assign accept = req_valid && req_ready && !reject;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = req_valid && req_ready && reject;
        case (state)
            IDLE: if (accept) state_nxt = BEAT0;
            BEAT0: begin
                if (mem_ready) begin
`ifdef STORE_MISALIGN_SPLIT_EN
                    if (cross_r) begin
                        state_nxt = BEAT1;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
`else
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
`endif
                end
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            BEAT1: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state      <= IDLE;
            store_done <= 1'b0;
            store_err  <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            be_r       <= '0;
`ifdef STORE_MISALIGN_SPLIT_EN
            cross_r    <= 1'b0;
            hi_wdata_r <= '0;
            hi_be_r    <= '0;
`endif
        end else begin
            state      <= state_nxt;
            store_done <= done_nxt;
            store_err  <= err_nxt;
            // Beat registers only change at accept or on the beat0->beat1
            // step, so they are stable while a beat is stalled.
            if (accept) begin
                addr_r  <= {req_addr[ADDR_W-1:2], 2'b00};
                wdata_r <= sh64[31:0];
                be_r    <= mask8[3:0];
`ifdef STORE_MISALIGN_SPLIT_EN
                cross_r    <= crosses;
                hi_wdata_r <= sh64[63:32];
                hi_be_r    <= mask8[7:4];
`endif
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            if (state == BEAT0 && mem_ready && cross_r) begin
                addr_r  <= addr_r + ADDR_W'(4);  // wraps past the top word
                wdata_r <= hi_wdata_r;
                be_r    <= hi_be_r;
            end
`endif
        end
    end

    // With ZERO_IDLE=0 the last beat's values stay visible while idle.
    always_comb begin
        if ((ZERO_IDLE != 0) && !mem_valid) begin
            mem_addr  = '0;
            mem_wdata = '0;
            mem_be    = '0;
        end else begin
            mem_addr  = addr_r;
            mem_wdata = wdata_r;
            mem_be    = be_r;
        end
    end

endmodule
